// File: rtl/regfile_pkg.sv
// Shared definitions for the architectural register file.
// Holds the data / register-index / ROB-tag widths and their range typedefs,
// the True/False constants and the hard-wired zero register index.
// Optional feature macro used elsewhere: REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;
  localparam int ROB_W  = 4;

  typedef logic [XLEN-1:0]   Data_Len;
  typedef logic [REG_AW-1:0] Reg_Addr_Len;
  typedef logic [ROB_W-1:0]  Rob_Addr_Len;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  localparam Reg_Addr_Len ZERO_REG = '0;

endpackage

// File: rtl/regfile_if.sv
// Bus between the issue stage / reorder buffer (master) and the register file (slave).
// Signals:
//   rdy                          global enable
//   has_misbranch                ROB flush pulse
//   issue_valid/rd/rob_num       destination rename from the issue stage
//   rs1/rs2_addr                 source operand indices
//   rs1/rs2_busy/rob_num/data    source operand lookup results
//   has_to_reg, dest_reg_num,
//   out_reg_data, out_reg_rob_num  in-order commit stream from the ROB
interface regfile_if;
  import regfile_pkg::*;

  logic        rdy;
  logic        has_misbranch;
  logic        issue_valid;
  Reg_Addr_Len issue_rd;
  Rob_Addr_Len issue_rob_num;
  Reg_Addr_Len rs1_addr;
  Reg_Addr_Len rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  Rob_Addr_Len rs1_rob_num;
  Rob_Addr_Len rs2_rob_num;
  Data_Len     rs1_data;
  Data_Len     rs2_data;
  logic        has_to_reg;
  Reg_Addr_Len dest_reg_num;
  Data_Len     out_reg_data;
  Rob_Addr_Len out_reg_rob_num;

  modport master (
    output rdy, has_misbranch, issue_valid, issue_rd, issue_rob_num,
    output rs1_addr, rs2_addr,
    input  rs1_busy, rs2_busy, rs1_rob_num, rs2_rob_num, rs1_data, rs2_data,
    output has_to_reg, dest_reg_num, out_reg_data, out_reg_rob_num
  );

  modport slave (
    input  rdy, has_misbranch, issue_valid, issue_rd, issue_rob_num,
    input  rs1_addr, rs2_addr,
    output rs1_busy, rs2_busy, rs1_rob_num, rs2_rob_num, rs1_data, rs2_data,
    input  has_to_reg, dest_reg_num, out_reg_data, out_reg_rob_num
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file.
// Ports:
//   addr_i                      register index to look up
//   data_i/busy_i/tag_i         full register state
//   commit_*_i                  same-cycle commit (only with REGFILE_BYPASS_EN)
//   busy_o/tag_o/data_o         lookup result; x0 always reads as all zero
// Macro REGFILE_BYPASS_EN: forward a matching same-cycle commit as a ready value.
module regfile_read_port
  import regfile_pkg::*;
(
  input  Reg_Addr_Len              addr_i,
  input  Data_Len     [NREG-1:0]   data_i,
  input  logic        [NREG-1:0]   busy_i,
  input  Rob_Addr_Len [NREG-1:0]   tag_i,
`ifdef REGFILE_BYPASS_EN
  input  logic                     commit_valid_i,
  input  Reg_Addr_Len              commit_reg_i,
  input  Data_Len                  commit_data_i,
  input  Rob_Addr_Len              commit_tag_i,
`endif
  output logic                     busy_o,
  output Rob_Addr_Len              tag_o,
  output Data_Len                  data_o
);

  always_comb begin
    busy_o = busy_i[addr_i];
    tag_o  = tag_i[addr_i];
    data_o = data_i[addr_i];
`ifdef REGFILE_BYPASS_EN
    // Only the commit of the current owner may forward; an older producer's
    // commit would otherwise hide the younger pending rename.
    if (commit_valid_i && (commit_reg_i == addr_i) && (addr_i != ZERO_REG) &&
        busy_i[addr_i] && (tag_i[addr_i] == commit_tag_i)) begin
      busy_o = False;
      data_o = commit_data_i;
    end
`endif
    if (addr_i == ZERO_REG) begin
      busy_o = False;
      tag_o  = '0;
      data_o = '0;
    end
  end

endmodule

// File: rtl/regfile.sv
// Architectural register file with rename status for the Tomasulo core.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   bus        regfile_if.slave: issue rename, two read ports, ROB commit/flush
// Each register holds a value, a busy flag and the ROB tag of its pending producer.
// Macro REGFILE_BYPASS_EN: read ports forward a same-cycle matching commit.
module regfile
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  Data_Len     [NREG-1:0] data_q, data_d;
  logic        [NREG-1:0] busy_q, busy_d;
  Rob_Addr_Len [NREG-1:0] tag_q,  tag_d;

  logic commit_en;
  logic rename_en;

  assign commit_en = bus.has_to_reg && (bus.dest_reg_num != ZERO_REG);
  assign rename_en = bus.issue_valid && !bus.has_misbranch && (bus.issue_rd != ZERO_REG);

  // Commit is applied first so that a same-cycle rename of the same register
  // overrides the busy clear; a flush clears every busy bit after both.
  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (commit_en) begin
      data_d[bus.dest_reg_num] = bus.out_reg_data;
      if (busy_q[bus.dest_reg_num] && (tag_q[bus.dest_reg_num] == bus.out_reg_rob_num))
        busy_d[bus.dest_reg_num] = False;
    end
    if (bus.has_misbranch) begin
      busy_d = '0;
    end else if (rename_en) begin
      busy_d[bus.issue_rd] = True;
      tag_d[bus.issue_rd]  = bus.issue_rob_num;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else if (bus.rdy) begin
      data_q <= data_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  regfile_read_port u_rs1 (
    .addr_i         (bus.rs1_addr),
    .data_i         (data_q),
    .busy_i         (busy_q),
    .tag_i          (tag_q),
`ifdef REGFILE_BYPASS_EN
    .commit_valid_i (bus.has_to_reg),
    .commit_reg_i   (bus.dest_reg_num),
    .commit_data_i  (bus.out_reg_data),
    .commit_tag_i   (bus.out_reg_rob_num),
`endif
    .busy_o         (bus.rs1_busy),
    .tag_o          (bus.rs1_rob_num),
    .data_o         (bus.rs1_data)
  );

  regfile_read_port u_rs2 (
    .addr_i         (bus.rs2_addr),
    .data_i         (data_q),
    .busy_i         (busy_q),
    .tag_i          (tag_q),
`ifdef REGFILE_BYPASS_EN
    .commit_valid_i (bus.has_to_reg),
    .commit_reg_i   (bus.dest_reg_num),
    .commit_data_i  (bus.out_reg_data),
    .commit_tag_i   (bus.out_reg_rob_num),
`endif
    .busy_o         (bus.rs2_busy),
    .tag_o          (bus.rs2_rob_num),
    .data_o         (bus.rs2_data)
  );

endmodule

// File: tb/tb_regfile.sv
// Testbench for regfile: directed scenarios followed by randomized traffic.
// A driver pushes the expected read-port results of each cycle into a queue;
// a monitor samples both read ports mid-cycle and compares against the queue.
module tb_regfile;
  import regfile_pkg::*;

  logic clk;
  logic rst;

  regfile_if bus ();

  regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          cycle;
    logic [4:0]  addr1;
    logic [4:0]  addr2;
    logic        busy1;
    logic        busy2;
    logic [3:0]  tag1;
    logic [3:0]  tag2;
    logic [31:0] data1;
    logic [31:0] data2;
    bit          chkTag1;
    bit          chkTag2;
  } expT;

  expT expQ[$];

  // Architectural model: plain arrays indexed by register number.
  logic [31:0] mData[32];
  bit          mBusy[32];
  logic [3:0]  mTag[32];

  int checks   = 0;
  int failures = 0;
  int cycleNum = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected view of one read port given the model state and the commit on the bus.
  task automatic expectPort(input logic [4:0] addr, input bit htr, input logic [4:0] dest,
                            input logic [31:0] odata, input logic [3:0] orob,
                            output logic busy, output logic [3:0] tag,
                            output logic [31:0] data, output bit chkTag);
    if (addr == 5'd0) begin
      busy = 1'b0; tag = 4'd0; data = 32'd0; chkTag = 1'b1;
    end else begin
      busy = mBusy[addr]; tag = mTag[addr]; data = mData[addr];
`ifdef REGFILE_BYPASS_EN
      if (htr && dest == addr && mBusy[addr] && mTag[addr] == orob) begin
        busy = 1'b0;
        data = odata;
      end
`else
      if (htr && dest == addr && orob == 4'hF && odata == 32'hFFFF_FFFF) busy = busy;
`endif
      chkTag = busy;
    end
  endtask

  task automatic applyStimulus(input bit rstV, input bit rdyV, input bit mis,
                               input bit iv, input logic [4:0] ird, input logic [3:0] irob,
                               input logic [4:0] a1, input logic [4:0] a2,
                               input bit htr, input logic [4:0] dest,
                               input logic [31:0] odata, input logic [3:0] orob);
    expT e;
    bit clr;
    @(posedge clk);
    #1;
    cycleNum++;
    rst                 = rstV;
    bus.rdy             = rdyV;
    bus.has_misbranch   = mis;
    bus.issue_valid     = iv;
    bus.issue_rd        = ird;
    bus.issue_rob_num   = irob;
    bus.rs1_addr        = a1;
    bus.rs2_addr        = a2;
    bus.has_to_reg      = htr;
    bus.dest_reg_num    = dest;
    bus.out_reg_data    = odata;
    bus.out_reg_rob_num = orob;
    if (rstV) begin
      for (int i = 0; i < 32; i++) begin
        mData[i] = '0; mBusy[i] = 1'b0; mTag[i] = '0;
      end
    end
    e.cycle = cycleNum;
    e.addr1 = a1;
    e.addr2 = a2;
    expectPort(a1, htr, dest, odata, orob, e.busy1, e.tag1, e.data1, e.chkTag1);
    expectPort(a2, htr, dest, odata, orob, e.busy2, e.tag2, e.data2, e.chkTag2);
    expQ.push_back(e);
    // Effects of this cycle become visible after the coming clock edge.
    if (!rstV && rdyV) begin
      if (htr && dest != 5'd0) begin
        clr = mBusy[dest] && (mTag[dest] == orob);
        mData[dest] = odata;
        if (clr) mBusy[dest] = 1'b0;
      end
      if (mis) begin
        for (int i = 0; i < 32; i++) mBusy[i] = 1'b0;
      end else if (iv && ird != 5'd0) begin
        mBusy[ird] = 1'b1;
        mTag[ird]  = irob;
      end
    end
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    applyStimulus(0, 1, 0, 0, 5'd0, 4'd0, a1, a2, 0, 5'd0, 32'd0, 4'd0);
  endtask

  // Monitor: read ports are always presenting data; sample mid-cycle.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput($sformatf("c%0d rs1_busy x%0d", e.cycle, e.addr1), {31'd0, bus.rs1_busy}, {31'd0, e.busy1});
        checkOutput($sformatf("c%0d rs1_data x%0d", e.cycle, e.addr1), bus.rs1_data, e.data1);
        if (e.chkTag1)
          checkOutput($sformatf("c%0d rs1_tag x%0d", e.cycle, e.addr1), {28'd0, bus.rs1_rob_num}, {28'd0, e.tag1});
        checkOutput($sformatf("c%0d rs2_busy x%0d", e.cycle, e.addr2), {31'd0, bus.rs2_busy}, {31'd0, e.busy2});
        checkOutput($sformatf("c%0d rs2_data x%0d", e.cycle, e.addr2), bus.rs2_data, e.data2);
        if (e.chkTag2)
          checkOutput($sformatf("c%0d rs2_tag x%0d", e.cycle, e.addr2), {28'd0, bus.rs2_rob_num}, {28'd0, e.tag2});
      end
    end
  end

  initial begin
    bit mis, iv, htr, rdyV, rstV;
    logic [4:0] ird, dest, a1, a2;
    logic [3:0] irob, orob;
    logic [31:0] odata;

    rst                 = 1'b1;
    bus.rdy             = 1'b1;
    bus.has_misbranch   = 1'b0;
    bus.issue_valid     = 1'b0;
    bus.issue_rd        = '0;
    bus.issue_rob_num   = '0;
    bus.rs1_addr        = '0;
    bus.rs2_addr        = '0;
    bus.has_to_reg      = 1'b0;
    bus.dest_reg_num    = '0;
    bus.out_reg_data    = '0;
    bus.out_reg_rob_num = '0;

    // Reset, then read x5 and x0.
    applyStimulus(1, 1, 0, 0, 5'd0, 4'd0, 5'd5, 5'd0, 0, 5'd0, 32'd0, 4'd0);
    idle(5'd5, 5'd0);
    idle(5'd0, 5'd5);

    // Rename x5 with tag 3, observe, commit it, observe.
    applyStimulus(0, 1, 0, 1, 5'd5, 4'd3, 5'd5, 5'd0, 0, 5'd0, 32'd0, 4'd0);
    idle(5'd5, 5'd5);
    applyStimulus(0, 1, 0, 0, 5'd0, 4'd0, 5'd5, 5'd0, 1, 5'd5, 32'h1234, 4'd3);
    idle(5'd5, 5'd5);

    // Older producer commits while a younger rename owns x7.
    applyStimulus(0, 1, 0, 1, 5'd7, 4'd2, 5'd7, 5'd0, 0, 5'd0, 32'd0, 4'd0);
    applyStimulus(0, 1, 0, 1, 5'd7, 4'd9, 5'd7, 5'd0, 0, 5'd0, 32'd0, 4'd0);
    applyStimulus(0, 1, 0, 0, 5'd0, 4'd0, 5'd7, 5'd7, 1, 5'd7, 32'hAA, 4'd2);
    idle(5'd7, 5'd0);

    // Same-cycle commit and rename of x4.
    applyStimulus(0, 1, 0, 1, 5'd4, 4'd6, 5'd4, 5'd0, 1, 5'd4, 32'h55, 4'd1);
    idle(5'd4, 5'd4);

    // Flush with simultaneous issue and commit.
    applyStimulus(0, 1, 0, 1, 5'd1, 4'd1, 5'd1, 5'd2, 0, 5'd0, 32'd0, 4'd0);
    applyStimulus(0, 1, 0, 1, 5'd2, 4'd2, 5'd1, 5'd2, 0, 5'd0, 32'd0, 4'd0);
    applyStimulus(0, 1, 0, 1, 5'd3, 4'd3, 5'd3, 5'd2, 0, 5'd0, 32'd0, 4'd0);
    applyStimulus(0, 1, 1, 1, 5'd8, 4'd5, 5'd1, 5'd3, 1, 5'd1, 32'h77, 4'd1);
    idle(5'd1, 5'd8);
    idle(5'd2, 5'd3);

    // Same-cycle commit seen on a read port (forwarded only with bypass).
    applyStimulus(0, 1, 0, 1, 5'd6, 4'd4, 5'd6, 5'd0, 0, 5'd0, 32'd0, 4'd0);
    applyStimulus(0, 1, 0, 0, 5'd0, 4'd0, 5'd6, 5'd6, 1, 5'd6, 32'hBEEF, 4'd4);
    idle(5'd6, 5'd0);

    // Hold while rdy is low: a rename must not land.
    applyStimulus(0, 0, 0, 1, 5'd9, 4'd7, 5'd9, 5'd0, 1, 5'd9, 32'h99, 4'd0);
    idle(5'd9, 5'd0);

    // Commit and rename of x0 are dropped.
    applyStimulus(0, 1, 0, 1, 5'd0, 4'd5, 5'd0, 5'd0, 1, 5'd0, 32'hDEAD, 4'd0);
    idle(5'd0, 5'd0);

    // Randomized traffic concentrated on a few registers to force collisions.
    for (int n = 0; n < 400; n++) begin
      rstV  = ($urandom % 120) == 0;
      rdyV  = ($urandom % 8) != 0;
      mis   = ($urandom % 16) == 0;
      iv    = ($urandom % 2) == 1;
      ird   = 5'($urandom % 8);
      irob  = 4'($urandom);
      htr   = ($urandom % 2) == 1;
      dest  = (($urandom % 8) == 0) ? 5'($urandom) : 5'($urandom % 8);
      orob  = (($urandom % 4) != 0) ? mTag[dest] : 4'($urandom);
      odata = $urandom;
      a1    = (($urandom % 3) == 0) ? dest : 5'($urandom % 8);
      a2    = (($urandom % 3) == 0) ? dest : 5'($urandom);
      applyStimulus(rstV, rdyV, mis, iv, ird, irob, a1, a2, htr, dest, odata, orob);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (expQ.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile.md
# regfile

Architectural register file with rename status for the Tomasulo core. It sits directly downstream of the reorder buffer: it consumes its in-order commit stream (`has_to_reg`, `dest_reg_num`, `out_reg_data`, `out_reg_rob_num`) and its `has_misbranch` flush. It also serves the issue stage, which reads source operands or their producing ROB tags and renames the destination of each issued instruction.

## Interface
- `XLEN`, 32: data width.
- `NREG`, 32: architectural registers; index 0 is hard-wired zero.
- `ROB_W`, 4: ROB tag width, 16 entries.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `rdy` in 1: global enable; when low, all state holds.
- `has_misbranch` in 1: ROB flush pulse.
- `issue_valid` in 1: issue stage renames a destination this cycle.
- `issue_rd` in 5: destination register of the issued instruction.
- `issue_rob_num` in ROB_W: ROB tag allocated to that instruction.
- `rs1_addr`, `rs2_addr` in 5 each: source register indices.
- `rs1_busy`, `rs2_busy` out 1 each: source is pending on a ROB entry.
- `rs1_rob_num`, `rs2_rob_num` out ROB_W each: producing ROB tag; valid when busy.
- `rs1_data`, `rs2_data` out XLEN each: architectural value; valid when not busy.
- `has_to_reg` in 1: ROB commit valid.
- `dest_reg_num` in 5: register being committed.
- `out_reg_data` in XLEN: committed value.
- `out_reg_rob_num` in ROB_W: ROB tag of the committing entry.

## Operation
- Per register state: `data[XLEN]`, `busy`, `tag[ROB_W]`. Register 0 is never written and never busy. Its reads always return data 0, busy 0, tag 0.
- Read ports are combinational from current state, plus the bypass described under Configuration.
- Commit, when `has_to_reg` and `dest_reg_num != 0`:
  - `data[dest] <= out_reg_data`, unconditionally.
  - If `busy[dest]` and `tag[dest] == out_reg_rob_num`, clear `busy[dest]`.
  - A tag mismatch means a younger producer still owns the register; busy and tag are unchanged.
- Rename, when `issue_valid && !has_misbranch && issue_rd != 0`: `busy[issue_rd] <= 1`, `tag[issue_rd] <= issue_rob_num`.
- Same register renamed and committed in one cycle: data is written, and the rename wins (busy=1, new tag).
- Flush, when `has_misbranch`:
  - Clear every busy bit.
  - Ignore issue in the same cycle.
  - A commit in the same cycle still writes data; the ROB emits a jalr commit together with the flush.
- Commit to x0 and rename of x0 are silently dropped.

## Timing
- All state updates happen at posedge `clk` when `rdy` is high, and are visible on the read ports the following cycle.
- Read latency is 0 cycles (combinational).
- Reset (async, `rst`=1): all data 0, busy 0, tag 0. Read outputs therefore are data 0, busy 0, tag 0 for every address.
- If reset is asserted mid-operation, all pending renames are lost immediately.

## Configuration
- `REGFILE_BYPASS_EN` defined: same-cycle commit forwarding on each read port. The port reports busy 0 and data `out_reg_data` when all of these hold:
  - `has_to_reg`;
  - `dest_reg_num == rsX_addr != 0`;
  - `busy[rsX_addr]`;
  - `tag[rsX_addr] == out_reg_rob_num`.
- `REGFILE_BYPASS_EN` undefined: reads show registered state only. The issue stage then relies on the ROB ready lookup for a value committing in the same cycle.

## Structure
- Shared package/config header holds:
  - `Data_Len`, `Reg_Addr_Len`, `Rob_Addr_Len` ranges;
  - `True`/`False`;
  - the zero-register index;
  - the ROB tag width.
- One natural sub-module, `regfile_read_port`: combinational lookup plus optional bypass, instantiated twice (rs1, rs2).

## Test plan
- Reset, then read x5 and x0 → data 0, busy 0 on both ports.
- Issue rd=5 with tag 3; next cycle read x5 → busy 1, tag 3. Then commit dest 5, tag 3, data 0x1234; next cycle → busy 0, data 0x1234.
- Issue rd=7 tag 2, then rd=7 tag 9, then commit dest 7 tag 2 data 0xAA → data 0xAA, busy 1, tag 9 persists.
- Same cycle: commit dest 4 tag 1 data 0x55 and issue rd=4 tag 6 → next cycle busy 1, tag 6, data 0x55.
- Rename x1, x2, x3; assert `has_misbranch` with simultaneous issue rd=8 and commit dest 1 data 0x77 → all busy 0, x8 not busy, x1 data 0x77.
- With `REGFILE_BYPASS_EN`: x6 busy with tag 4, commit dest 6 tag 4 data 0xBEEF, rs1_addr=6 in the same cycle → rs1_busy 0, rs1_data 0xBEEF combinationally. Without the macro → busy 1 that cycle.
